// File: rtl/sp_sram_arb.sv
// sp_sram_arb: round-robin arbiter and init sequencer for one single-port SRAM.
// After reset an optional sweep writes INIT_VALUE to words 0..DEPTH-1. Two
// requesters then share the SRAM with one access per cycle. Read data comes
// back with a one-cycle valid strobe, aligned with the SRAM's registered qout.
module sp_sram_arb #(
  parameter int                    ADDR_WIDTH = 4,
  parameter int                    DATA_WIDTH = 16,
  parameter int                    DEPTH      = 2**ADDR_WIDTH,
  parameter int                    INIT_EN    = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  gnt0,
  output logic                  rvalid0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt1,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  output logic                  sram_wr,
  input  logic [DATA_WIDTH-1:0] sram_qout
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam state_t                RESET_STATE = (INIT_EN != 0) ? ST_INIT : ST_RUN;
  localparam logic                  RESET_DONE  = (INIT_EN != 0) ? 1'b0 : 1'b1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(DEPTH - 1);

  state_t                  state_r, next_state_s;
  logic [ADDR_WIDTH-1:0]   init_cnt_r, init_cnt_next_s;
  logic                    init_done_r, init_done_next_s;
  logic                    rr_ptr_r;
  logic                    rvalid0_r, rvalid1_r;
  logic                    gnt0_s, gnt1_s;
  logic [ADDR_WIDTH-1:0]   sram_addr_s;
  logic [DATA_WIDTH-1:0]   sram_din_s;
  logic                    sram_wr_s;

  // Sequencer state: FSM state, sweep counter and init_done flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= RESET_STATE;
      init_cnt_r  <= '0;
      init_done_r <= RESET_DONE;
    end else begin
      state_r     <= next_state_s;
      init_cnt_r  <= init_cnt_next_s;
      init_done_r <= init_done_next_s;
    end
  end

  // Next state, sweep drive and same-cycle round-robin arbitration.
  always_comb begin
    next_state_s     = state_r;
    init_cnt_next_s  = init_cnt_r;
    init_done_next_s = init_done_r;
    gnt0_s           = 1'b0;
    gnt1_s           = 1'b0;
    sram_addr_s      = '0;
    sram_din_s       = '0;
    sram_wr_s        = 1'b0;
    case (state_r)
      ST_INIT: begin
        // Requests are held off (not dropped) until the sweep finishes.
        sram_wr_s   = 1'b1;
        sram_addr_s = init_cnt_r;
        sram_din_s  = INIT_VALUE;
        if (init_cnt_r == LAST_ADDR) begin
          next_state_s     = ST_RUN;
          init_done_next_s = 1'b1;
          init_cnt_next_s  = '0;
        end else begin
          init_cnt_next_s  = init_cnt_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        end
      end
      ST_RUN: begin
        // Port 0 wins when alone or when it holds the round-robin turn.
        if (req0 && (!req1 || (rr_ptr_r == 1'b0))) begin
          gnt0_s      = 1'b1;
          sram_addr_s = addr0;
          sram_din_s  = wdata0;
          sram_wr_s   = we0;
        end else if (req1) begin
          gnt1_s      = 1'b1;
          sram_addr_s = addr1;
          sram_din_s  = wdata1;
          sram_wr_s   = we1;
        end else begin
          gnt0_s      = 1'b0;
          gnt1_s      = 1'b0;
        end
      end
      default: begin
        next_state_s = RESET_STATE;
      end
    endcase
  end

  // Round-robin pointer moves to the other port after each grant; read strobes
  // line up with the SRAM's registered qout one cycle after a read grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_r  <= 1'b0;
      rvalid0_r <= 1'b0;
      rvalid1_r <= 1'b0;
    end else begin
      if (gnt0_s) begin
        rr_ptr_r <= 1'b1;
      end else if (gnt1_s) begin
        rr_ptr_r <= 1'b0;
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
      rvalid0_r <= gnt0_s & ~we0;
      rvalid1_r <= gnt1_s & ~we1;
    end
  end

  assign gnt0      = gnt0_s;
  assign gnt1      = gnt1_s;
  assign sram_addr = sram_addr_s;
  assign sram_din  = sram_din_s;
  assign sram_wr   = sram_wr_s;
  assign init_done = init_done_r;
  assign rvalid0   = rvalid0_r;
  assign rvalid1   = rvalid1_r;
  // Gate qout so the SRAM's undefined post-write output never leaks out.
  assign rdata0    = rvalid0_r ? sram_qout : '0;
  assign rdata1    = rvalid1_r ? sram_qout : '0;

endmodule

// File: tb/tb_sp_sram_arb.sv
// Testbench for sp_sram_arb: behavioural single-port SRAM, directed stimulus
// with hand-computed expectations, and a read-data scoreboard per port.
module tb_sp_sram_arb;
  localparam int AW = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1, init_done;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din, sram_qout;
  logic          sram_wr;
  logic [DW-1:0] mem [16];

  int n_vec = 0;
  int n_err = 0;
  logic [DW-1:0] q0 [$];
  logic [DW-1:0] q1 [$];

  sp_sram_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(16), .INIT_EN(1),
                .INIT_VALUE(16'h0000)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .init_done(init_done), .sram_addr(sram_addr), .sram_din(sram_din),
    .sram_wr(sram_wr), .sram_qout(sram_qout)
  );

  always #5 clk = ~clk;

  // Single-port SRAM with registered output; output undefined after a write.
  always @(posedge clk) begin
    if (sram_wr) begin
      mem[sram_addr] <= sram_din;
      sram_qout      <= 'x;
    end else begin
      sram_qout      <= mem[sram_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #3;
  endtask

  // Monitor: pop and compare whenever a read strobe is presented.
  always @(negedge clk) begin
    if (!rst) begin
      if (rvalid0) begin
        if (q0.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL rvalid0_unexpected: got rdata0 %h expected no strobe", rdata0);
        end else begin
          chk("rdata0", 32'(rdata0), 32'(q0.pop_front()));
        end
      end else begin
        chk("rdata0_idle", 32'(rdata0), 32'h0);
      end
      if (rvalid1) begin
        if (q1.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL rvalid1_unexpected: got rdata1 %h expected no strobe", rdata1);
        end else begin
          chk("rdata1", 32'(rdata1), 32'(q1.pop_front()));
        end
      end else begin
        chk("rdata1_idle", 32'(rdata1), 32'h0);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0n;
    int p1n;
    rst = 1'b1;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    tick; tick;
    settle;
    chk("rst_init_done", 32'(init_done), 32'h0);
    chk("rst_gnt0", 32'(gnt0), 32'h0);
    chk("rst_gnt1", 32'(gnt1), 32'h0);
    chk("rst_rvalid0", 32'(rvalid0), 32'h0);
    chk("rst_rvalid1", 32'(rvalid1), 32'h0);
    chk("rst_sram_wr", 32'(sram_wr), 32'h1);
    chk("rst_sram_addr", 32'(sram_addr), 32'h0);

    // Partial sweep, then reset when init_cnt reaches 7.
    tick;
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      settle;
      chk("sweep1_addr", 32'(sram_addr), 32'(i));
      chk("sweep1_wr", 32'(sram_wr), 32'h1);
      tick;
    end
    settle;
    chk("sweep1_addr7", 32'(sram_addr), 32'h7);
    rst = 1'b1;
    #1;
    chk("midrst_addr", 32'(sram_addr), 32'h0);
    chk("midrst_init_done", 32'(init_done), 32'h0);
    tick;
    rst = 1'b0;

    // Full sweep; port 1 requests a read of addr 9 from cycle 3.
    for (int i = 0; i < 16; i++) begin
      if (i == 3) begin
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'd9;
      end
      settle;
      chk("sweep_addr", 32'(sram_addr), 32'(i));
      chk("sweep_wr", 32'(sram_wr), 32'h1);
      chk("sweep_din", 32'(sram_din), 32'h0);
      chk("sweep_init_done", 32'(init_done), 32'h0);
      chk("sweep_gnt1", 32'(gnt1), 32'h0);
      tick;
    end
    settle;
    chk("run_init_done", 32'(init_done), 32'h1);
    chk("run_first_gnt1", 32'(gnt1), 32'h1);
    chk("run_first_gnt0", 32'(gnt0), 32'h0);
    chk("run_first_addr", 32'(sram_addr), 32'h9);
    q1.push_back(16'h0000);
    tick;
    req1 = 1'b0;

    // Port 0 reads every word; all hold the init value.
    for (int i = 0; i < 16; i++) begin
      req0 = 1'b1; we0 = 1'b0; addr0 = 4'(i);
      settle;
      chk("rd_all_gnt0", 32'(gnt0), 32'h1);
      q0.push_back(16'h0000);
      tick;
    end
    req0 = 1'b0;
    settle;
    chk("idle_wr", 32'(sram_wr), 32'h0);
    chk("idle_addr", 32'(sram_addr), 32'h0);
    chk("idle_gnt", 32'({gnt1, gnt0}), 32'h0);
    tick;

    // Write 0xBEEF to addr 5 then read it back on the next cycle.
    req0 = 1'b1; we0 = 1'b1; addr0 = 4'd5; wdata0 = 16'hBEEF;
    settle;
    chk("wr5_gnt0", 32'(gnt0), 32'h1);
    chk("wr5_din", 32'(sram_din), 32'hBEEF);
    chk("wr5_wr", 32'(sram_wr), 32'h1);
    tick;
    we0 = 1'b0;
    settle;
    chk("rd5_gnt0", 32'(gnt0), 32'h1);
    chk("rd5_no_rvalid_after_write", 32'(rvalid0), 32'h0);
    q0.push_back(16'hBEEF);
    tick;
    req0 = 1'b0;
    settle;
    chk("rd5_rvalid0", 32'(rvalid0), 32'h1);
    chk("rd5_rvalid1", 32'(rvalid1), 32'h0);
    tick;
    settle;
    chk("rd5_rvalid0_drop", 32'(rvalid0), 32'h0);
    tick;

    // Preload addr i = 0x1000+i; a port-1 write leaves rr_ptr at 0.
    for (int i = 0; i < 8; i++) begin
      req0 = 1'b1; we0 = 1'b1; addr0 = 4'(i); wdata0 = 16'h1000 + 16'(i);
      settle;
      chk("pre_gnt0", 32'(gnt0), 32'h1);
      tick;
    end
    req0 = 1'b0; we0 = 1'b0;
    req1 = 1'b1; we1 = 1'b1; addr1 = 4'd8; wdata1 = 16'h2008;
    settle;
    chk("pre_gnt1", 32'(gnt1), 32'h1);
    tick;
    we1 = 1'b0;

    // Continuous contention: grants alternate 0,1,0,1,...
    p0n = 0; p1n = 0;
    for (int i = 0; i < 8; i++) begin
      req0 = 1'b1; addr0 = 4'(p0n);
      req1 = 1'b1; addr1 = 4'(4 + p1n);
      settle;
      chk("rr_gnt0", 32'(gnt0), 32'((i % 2) == 0));
      chk("rr_gnt1", 32'(gnt1), 32'((i % 2) == 1));
      if ((i % 2) == 0) begin
        q0.push_back(16'h1000 + 16'(p0n)); p0n++;
      end else begin
        q1.push_back(16'h1004 + 16'(p1n)); p1n++;
      end
      tick;
    end
    req0 = 1'b0; req1 = 1'b0;

    // rr_ptr = 0: write 0x1234 wins over read of old 0xAAAA.
    req1 = 1'b1; we1 = 1'b1; addr1 = 4'd3; wdata1 = 16'hAAAA;
    settle;
    chk("raw_setup_gnt1", 32'(gnt1), 32'h1);
    tick;
    req0 = 1'b1; we0 = 1'b1; addr0 = 4'd3; wdata0 = 16'h1234;
    we1 = 1'b0;
    settle;
    chk("raw_gnt0", 32'(gnt0), 32'h1);
    chk("raw_gnt1_wait", 32'(gnt1), 32'h0);
    tick;
    req0 = 1'b0;
    settle;
    chk("raw_gnt1", 32'(gnt1), 32'h1);
    q1.push_back(16'h1234);
    tick;
    req1 = 1'b0;

    // rr_ptr = 1: read wins and sees 0xAAAA, then the write lands.
    req0 = 1'b1; we0 = 1'b1; addr0 = 4'd3; wdata0 = 16'hAAAA;
    settle;
    chk("war_setup_gnt0", 32'(gnt0), 32'h1);
    tick;
    wdata0 = 16'h1234;
    req1 = 1'b1; we1 = 1'b0; addr1 = 4'd3;
    settle;
    chk("war_gnt1", 32'(gnt1), 32'h1);
    chk("war_gnt0_wait", 32'(gnt0), 32'h0);
    q1.push_back(16'hAAAA);
    tick;
    req1 = 1'b0;
    settle;
    chk("war_gnt0", 32'(gnt0), 32'h1);
    tick;
    we0 = 1'b0;
    settle;
    chk("war_check_gnt0", 32'(gnt0), 32'h1);
    q0.push_back(16'h1234);
    tick;
    req0 = 1'b0;
    tick; tick;

    chk("q0_drained", 32'(q0.size()), 32'h0);
    chk("q1_drained", 32'(q1.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sp_sram_arb.md
Name: sp_sram_arb

Overview:
- Two-port round-robin arbiter and init sequencer for one single-port SRAM instance, used as FPU scratch/register storage.
- After reset, an optional sweep writes INIT_VALUE to every word.
- Two requesters then share the SRAM at one access per cycle; read data is returned with a one-cycle valid strobe.
- The block drives the SRAM's addr/din/wr pins and receives its registered qout.

Parameters:
ADDR_WIDTH, 4, SRAM address width
DATA_WIDTH, 16, SRAM data width
DEPTH, 2**ADDR_WIDTH, number of words swept by init
INIT_EN, 1, 1 = run init sweep after reset; 0 = skip it
INIT_VALUE, 0, word written during the sweep

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
req0  in  1  port 0 access request
we0  in  1  port 0 write (1) / read (0)
addr0  in  ADDR_WIDTH  port 0 address
wdata0  in  DATA_WIDTH  port 0 write data
gnt0  out  1  port 0 granted this cycle
rvalid0  out  1  port 0 read data valid
rdata0  out  DATA_WIDTH  port 0 read data
req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1  as port 0, for port 1
init_done  out  1  init sweep complete, grants enabled
sram_addr  out  ADDR_WIDTH  to SRAM addr
sram_din  out  DATA_WIDTH  to SRAM din
sram_wr  out  1  to SRAM wr
sram_qout  in  DATA_WIDTH  from SRAM qout; valid the cycle after a read edge

Behaviour:
- States: INIT, RUN.
- Reset:
  - state = INIT if INIT_EN else RUN; init_cnt = 0; rr_ptr = 0; rvalid0/1 = 0.
  - init_done = 0 if INIT_EN else 1.
  - Combinational outputs take their INIT/RUN-idle values.
- INIT:
  - sram_wr = 1, sram_addr = init_cnt, sram_din = INIT_VALUE; init_cnt increments each cycle.
  - When init_cnt == DEPTH-1: next state = RUN and init_done <= 1, so init_done goes high on the same edge as the last write.
  - gnt0 = gnt1 = 0 throughout INIT; requests are held off, not dropped.
  - DEPTH < 2**ADDR_WIDTH: sweep covers only 0..DEPTH-1.
- RUN arbitration (combinational, same cycle as req):
  - Only reqk high: grant port k.
  - Both high: grant port rr_ptr.
  - Neither high: no grant; sram_wr = 0; sram_addr/sram_din = 0.
- Grants: one grant max per cycle, gnt0 & gnt1 never both 1. The access commits on the clk edge where gntk is high.
- Requester contract: hold reqk/wek/addrk/wdatak stable until gntk is sampled high. It may deassert reqk or issue a new request the following cycle.
- Granted port k drives the SRAM: sram_addr = addrk, sram_din = wdatak, sram_wr = wek.
- rr_ptr: after any grant to port k, rr_ptr <= ~k. Unchanged when there is no grant. Under continuous contention, grants strictly alternate.
- Read return:
  - rvalidk <= gntk & ~wek (registered), so rvalidk is high exactly one cycle after a read grant.
  - rdatak = sram_qout while rvalidk is high, else 0. Never forward the SRAM's X-after-write output.
- Write: no response beyond gntk; the write is visible to any read granted on a later cycle.
- Write then read, same address, consecutive cycles (either port): the read returns the new data.
- Same-cycle read and write to the same address from different ports: the loser waits. Its result reflects the winner's access (read-after-write or write-after-read order, per rr_ptr).
- Back-to-back reads from the same port: one grant per cycle; rvalid may stay high for consecutive cycles.
- Reset asserted mid-INIT or mid-RUN: immediate return to reset state; sweep restarts from 0.
  - Pending rvalid is cleared; the outstanding read is lost, and the requester must reissue it after reset.

Test Plan:
- INIT_EN=1, DEPTH=16, INIT_VALUE=0x0000: release rst -> sram_wr high with sram_addr 0..15 over 16 cycles; init_done rises after the 16th edge. Port 0 reads addr 0..15 -> all rdata0 = 0x0000.
- Port 0 writes 0xBEEF to addr 5, then reads addr 5 next cycle -> gnt0 on both cycles; rvalid0 exactly one cycle after the read grant, rdata0 = 0xBEEF; rvalid1 stays 0.
- Both ports hold req (reads) for 8 cycles after init -> grants 0,1,0,1,0,1,0,1; each rvalid pulse follows its grant by one cycle with the correct word.
- req1 asserted during INIT at cycle 3 -> gnt1 = 0 until init_done = 1, then granted in the first RUN cycle; sram_wr never 0 during the sweep.
- Assert rst when init_cnt = 7 -> all outputs return to reset values; sweep restarts at addr 0 and completes 16 cycles after release.
- rr_ptr = 0; port 0 writes 0x1234 to addr 3 while port 1 reads addr 3 (old value 0xAAAA) -> gnt0 first, then gnt1; rdata1 = 0x1234. Repeat with rr_ptr = 1 -> rdata1 = 0xAAAA.
